// File: rtl/sequence_checker.sv
// sequence_checker: receive-side monitor for the repeating 8-byte pattern
// AF BC E2 78 FF E2 0B 8D. It acquires alignment on 0xAF, moves through
// HUNT -> SYNC -> LOCKED, and reports per-byte match/err pulses, completed
// sequences and a lock flag. All outputs are registered (1-cycle latency).
// Optional build macro: SEQCHK_ERR_COUNT_EN builds the saturating error
// counter; without it err_count is tied to zero.
module sequence_checker #(
  parameter int LOCK_SEQS   = 1,
  parameter int UNLOCK_ERRS = 3,
  parameter int ERR_CNT_W   = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [7:0]           data,
  output logic                 locked,
  output logic                 match,
  output logic                 err,
  output logic                 seq_done,
  output logic [7:0]           expected,
  output logic [ERR_CNT_W-1:0] err_count
);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    SYNC   = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam logic [63:0] PATTERN    = 64'hAF_BC_E2_78_FF_E2_0B_8D;
  localparam logic [7:0]  START      = 8'hAF;
  localparam logic [4:0]  LOCK_TGT   = 5'(LOCK_SEQS);
  localparam logic [3:0]  UNLOCK_TGT = 4'(UNLOCK_ERRS);

  // Pattern table, byte 0 is the most significant byte of PATTERN.
  logic [7:0] rom [8];
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_rom
      assign rom[gi] = PATTERN[63-8*gi -: 8];
    end
  endgenerate

  state_t     state_reg;
  logic [2:0] idx_reg;
  logic [3:0] good_seqs_reg;
  logic [2:0] miss_reg;

  logic       hit;
  logic [2:0] idx_inc;
  logic [4:0] good_inc;
  logic [3:0] miss_inc;

  assign hit      = (data == rom[idx_reg]);
  assign idx_inc  = idx_reg + 3'd1;          // 3-bit index wraps 7 -> 0
  assign good_inc = {1'b0, good_seqs_reg} + 5'd1;
  assign miss_inc = {1'b0, miss_reg} + 4'd1;

  // Alignment FSM with registered pulse, lock and expected-byte outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= HUNT;
      idx_reg       <= 3'd0;
      good_seqs_reg <= 4'd0;
      miss_reg      <= 3'd0;
      locked        <= 1'b0;
      match         <= 1'b0;
      err           <= 1'b0;
      seq_done      <= 1'b0;
      expected      <= START;
    end else begin
      match    <= 1'b0;
      err      <= 1'b0;
      seq_done <= 1'b0;
      if (enable) begin
        case (state_reg)
          HUNT: begin
            // The start byte is the only unambiguous sync point.
            if (data == START) begin
              state_reg     <= SYNC;
              idx_reg       <= 3'd1;
              good_seqs_reg <= 4'd0;
              expected      <= rom[1];
            end
          end
          SYNC: begin
            if (hit) begin
              match <= 1'b1;
              if (idx_reg == 3'd7) begin
                seq_done      <= 1'b1;
                good_seqs_reg <= good_inc[3:0];
                if (good_inc >= LOCK_TGT) begin
                  state_reg <= LOCKED;
                  locked    <= 1'b1;
                  miss_reg  <= 3'd0;
                end
              end
              idx_reg  <= idx_inc;
              expected <= rom[idx_inc];
            end else if (data == START) begin
              // Repeated start bytes simply restart the alignment.
              idx_reg       <= 3'd1;
              good_seqs_reg <= 4'd0;
              expected      <= rom[1];
            end else begin
              state_reg <= HUNT;
              idx_reg   <= 3'd0;
              expected  <= START;
            end
          end
          LOCKED: begin
            // Flywheel: the index keeps running even across bad bytes.
            if (hit) begin
              match    <= 1'b1;
              miss_reg <= 3'd0;
              if (idx_reg == 3'd7) seq_done <= 1'b1;
              idx_reg  <= idx_inc;
              expected <= rom[idx_inc];
            end else begin
              err <= 1'b1;
              if (miss_inc >= UNLOCK_TGT) begin
                state_reg <= HUNT;
                locked    <= 1'b0;
                miss_reg  <= 3'd0;
                idx_reg   <= 3'd0;
                expected  <= START;
              end else begin
                miss_reg <= miss_inc[2:0];
                idx_reg  <= idx_inc;
                expected <= rom[idx_inc];
              end
            end
          end
          default: begin
            state_reg <= HUNT;
            idx_reg   <= 3'd0;
            locked    <= 1'b0;
            expected  <= START;
          end
        endcase
      end
    end
  end

`ifdef SEQCHK_ERR_COUNT_EN
  logic [ERR_CNT_W-1:0] err_count_reg;

  // Saturating count of mismatches seen while locked; only reset clears it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_count_reg <= '0;
    end else if (enable && state_reg == LOCKED && !hit && err_count_reg != '1) begin
      err_count_reg <= err_count_reg + ERR_CNT_W'(1);
    end
  end

  assign err_count = err_count_reg;
`else
  assign err_count = '0;
`endif

endmodule

// File: tb/tb_sequence_checker.sv
// tb_sequence_checker: directed scenarios plus a randomized stream checked
// against a behavioural model of the pattern-alignment rules.
module tb_sequence_checker;

  localparam int LOCK_SEQS   = 1;
  localparam int UNLOCK_ERRS = 3;
  localparam int ERR_CNT_W   = 8;
`ifdef SEQCHK_ERR_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic                 clk;
  logic                 reset;
  logic                 enable;
  logic [7:0]           data;
  logic                 locked;
  logic                 match;
  logic                 err;
  logic                 seq_done;
  logic [7:0]           expected;
  logic [ERR_CNT_W-1:0] err_count;

  int checks = 0;
  int errors = 0;

  logic [7:0] pat [8] = '{8'hAF, 8'hBC, 8'hE2, 8'h78, 8'hFF, 8'hE2, 8'h0B, 8'h8D};

  // Reference model state: mode 0 = hunt, 1 = sync, 2 = locked.
  int   m_mode, m_pos, m_good, m_miss, m_ecnt;
  logic m_match, m_err, m_done;

  sequence_checker #(
    .LOCK_SEQS  (LOCK_SEQS),
    .UNLOCK_ERRS(UNLOCK_ERRS),
    .ERR_CNT_W  (ERR_CNT_W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .data     (data),
    .locked   (locked),
    .match    (match),
    .err      (err),
    .seq_done (seq_done),
    .expected (expected),
    .err_count(err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (time %0t, limit 2000000)", $time);
    $fatal(1, "watchdog expired");
  end

  function automatic int exp_cnt(input int n);
    return CNT_EN ? n : 0;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_pos = 0; m_good = 0; m_miss = 0; m_ecnt = 0;
    m_match = 1'b0; m_err = 1'b0; m_done = 1'b0;
  endtask

  task automatic model_step(input logic [7:0] d, input logic en);
    m_match = 1'b0; m_err = 1'b0; m_done = 1'b0;
    if (en) begin
      if (m_mode == 0) begin
        if (d == 8'hAF) begin m_mode = 1; m_pos = 1; m_good = 0; end
      end else if (m_mode == 1) begin
        if (d == pat[m_pos]) begin
          m_match = 1'b1;
          if (m_pos == 7) begin
            m_done = 1'b1;
            m_good++;
            if (m_good >= LOCK_SEQS) begin m_mode = 2; m_miss = 0; end
          end
          m_pos = (m_pos + 1) % 8;
        end else if (d == 8'hAF) begin
          m_pos = 1; m_good = 0;
        end else begin
          m_mode = 0; m_pos = 0;
        end
      end else begin
        if (d == pat[m_pos]) begin
          m_match = 1'b1; m_miss = 0;
          if (m_pos == 7) m_done = 1'b1;
        end else begin
          m_err = 1'b1; m_miss++;
          if (m_ecnt < (1 << ERR_CNT_W) - 1) m_ecnt++;
        end
        m_pos = (m_pos + 1) % 8;
        if (m_miss >= UNLOCK_ERRS) begin m_mode = 0; m_pos = 0; m_miss = 0; end
      end
    end
  endtask

  task automatic send(input logic [7:0] d, input logic en);
    @(negedge clk);
    data = d; enable = en;
    @(posedge clk);
    #1;
    model_step(d, en);
    $display("tx data=%02h en=%0b locked=%0b match=%0b err=%0b done=%0b exp=%02h ecnt=%0d",
             d, en, locked, match, err, seq_done, expected, err_count);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0; enable = 1'b0; data = 8'h00;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    model_reset();
  endtask

  task automatic acquire();
    for (int i = 0; i < 8; i++) send(pat[i], 1'b1);
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++;
    if ({locked, match, err, seq_done} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags: got %b want 0000", {locked, match, err, seq_done});
    end
    checks++;
    if (expected !== 8'hAF) begin
      errors++; $display("FAIL reset_expected: got %02h want af", expected);
    end
    checks++;
    if (err_count !== '0) begin
      errors++; $display("FAIL reset_err_count: got %0d want 0", err_count);
    end
  endtask

  task automatic test_acquire();
    do_reset();
    send(8'hAF, 1'b1);
    checks++;
    if (match !== 1'b0 || expected !== 8'hBC) begin
      errors++; $display("FAIL acq_first_af: match=%b exp=%02h want match=0 exp=bc", match, expected);
    end
    for (int i = 1; i < 8; i++) begin
      send(pat[i], 1'b1);
      checks++;
      if (match !== 1'b1 || seq_done !== (i == 7)) begin
        errors++; $display("FAIL acq_byte%0d: match=%b done=%b want match=1 done=%b", i, match, seq_done, i == 7);
      end
    end
    checks++;
    if (locked !== 1'b1 || expected !== 8'hAF) begin
      errors++; $display("FAIL acq_locked: locked=%b exp=%02h want locked=1 exp=af", locked, expected);
    end
  endtask

  task automatic test_double_af();
    do_reset();
    send(8'hAF, 1'b1);
    send(8'hAF, 1'b1);
    checks++;
    if (match !== 1'b0 || expected !== 8'hBC || locked !== 1'b0) begin
      errors++; $display("FAIL dbl_af_restart: match=%b exp=%02h locked=%b want 0/bc/0", match, expected, locked);
    end
    for (int i = 1; i < 8; i++) begin
      send(pat[i], 1'b1);
      checks++;
      if (match !== 1'b1) begin
        errors++; $display("FAIL dbl_af_byte%0d: match=%b want 1", i, match);
      end
    end
    checks++;
    if (locked !== 1'b1) begin
      errors++; $display("FAIL dbl_af_locked: locked=%b want 1", locked);
    end
  endtask

  task automatic test_single_err();
    do_reset();
    acquire();
    send(8'hAF, 1'b1);
    send(8'h00, 1'b1);
    checks++;
    if (err !== 1'b1 || match !== 1'b0 || locked !== 1'b1 || err_count !== ERR_CNT_W'(exp_cnt(1))) begin
      errors++; $display("FAIL single_err: err=%b match=%b locked=%b cnt=%0d want 1/0/1/%0d",
                         err, match, locked, err_count, exp_cnt(1));
    end
    send(8'hE2, 1'b1);
    checks++;
    if (match !== 1'b1 || err !== 1'b0 || locked !== 1'b1 || expected !== 8'h78) begin
      errors++; $display("FAIL flywheel: match=%b err=%b locked=%b exp=%02h want 1/0/1/78",
                         match, err, locked, expected);
    end
  endtask

  task automatic test_unlock();
    do_reset();
    acquire();
    for (int i = 0; i < 3; i++) begin
      send(8'h55, 1'b1);
      checks++;
      if (err !== 1'b1 || locked !== (i < 2) || err_count !== ERR_CNT_W'(exp_cnt(i + 1))) begin
        errors++; $display("FAIL unlock_bad%0d: err=%b locked=%b cnt=%0d want 1/%b/%0d",
                           i, err, locked, err_count, i < 2, exp_cnt(i + 1));
      end
    end
    checks++;
    if (expected !== 8'hAF) begin
      errors++; $display("FAIL unlock_expected: got %02h want af", expected);
    end
  endtask

  task automatic test_enable_gap();
    do_reset();
    for (int i = 0; i < 4; i++) send(pat[i], 1'b1);
    for (int i = 0; i < 5; i++) begin
      send(8'hFF, 1'b0);
      checks++;
      if ({match, err, seq_done} !== 3'b000 || expected !== 8'hFF) begin
        errors++; $display("FAIL gap_cycle%0d: pulses=%b exp=%02h want 000/ff", i, {match, err, seq_done}, expected);
      end
    end
    send(8'hFF, 1'b1);
    checks++;
    if (match !== 1'b1 || expected !== 8'hE2) begin
      errors++; $display("FAIL gap_resume: match=%b exp=%02h want 1/e2", match, expected);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    acquire();
    send(8'hAF, 1'b1);
    send(8'h11, 1'b1);
    send(8'hE2, 1'b1);
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (locked !== 1'b0 || expected !== 8'hAF || err_count !== '0) begin
      errors++; $display("FAIL async_reset: locked=%b exp=%02h cnt=%0d want 0/af/0", locked, expected, err_count);
    end
    @(negedge clk);
    reset = 1'b1;
    enable = 1'b0;
    model_reset();
  endtask

  task automatic test_random();
    int gpos;
    int r;
    logic [7:0] d;
    logic en;
    do_reset();
    gpos = 0;
    for (int n = 0; n < 800; n++) begin
      en = ($urandom_range(0, 9) != 0);
      r  = $urandom_range(0, 99);
      if (r < 80)      d = pat[gpos];
      else if (r < 88) d = 8'hAF;
      else             d = 8'($urandom);
      if (r >= 97) gpos = $urandom_range(0, 7);
      else if (en) gpos = (gpos + 1) % 8;
      send(d, en);
      checks++;
      if ({locked, match, err, seq_done, expected, err_count} !==
          {m_mode == 2, m_match, m_err, m_done, pat[m_pos], ERR_CNT_W'(exp_cnt(m_ecnt))}) begin
        errors++;
        $display("FAIL random_cycle%0d: got l=%b m=%b e=%b d=%b exp=%02h cnt=%0d want l=%b m=%b e=%b d=%b exp=%02h cnt=%0d",
                 n, locked, match, err, seq_done, expected, err_count,
                 m_mode == 2, m_match, m_err, m_done, pat[m_pos], exp_cnt(m_ecnt));
      end
    end
  endtask

  initial begin
    reset  = 1'b0;
    enable = 1'b0;
    data   = 8'h00;
    model_reset();
    test_reset();
    test_acquire();
    test_double_af();
    test_single_err();
    test_unlock();
    test_enable_gap();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
